// File: rtl/mdu_iter_hilo.sv
// ============================================================================
// Module   : mdu_iter_hilo
// Brief    : Multiply/divide unit with HI/LO, pipelined multiply latency and
//            iterative restoring divide. Optional MDU_MADD_EN enables madd/msub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter_hilo #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_MAX = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    // Shared work register: product for multiplies, {remainder, quotient} for divides.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               negq_q, negq_d, negr_q, negr_d;
    logic               divz_q, divz_d;

    logic               w_accept, w_is_mul, w_is_div, w_is_mt, w_is_acc;
    logic               w_mul_signed, w_div_signed;
    logic [2*WIDTH-1:0] w_opa, w_opb, w_prod;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_rem, w_quo, w_q_fix, w_r_fix;
    logic [2*WIDTH-1:0] w_hilo, w_mul_wr;

`ifdef MDU_MADD_EN
    localparam logic [1:0] C_MODE_SET = 2'd0;
    localparam logic [1:0] C_MODE_ADD = 2'd1;
    localparam logic [1:0] C_MODE_SUB = 2'd2;
    logic [1:0] mode_q, mode_d;
    assign w_is_acc = (op >= 4'd9) && (op <= 4'd12);
`else
    assign w_is_acc = 1'b0;
`endif

    assign w_accept     = start & ~busy & ~flush;
    assign w_is_mul     = (op == 4'd1) || (op == 4'd2);
    assign w_is_div     = (op == 4'd3) || (op == 4'd4);
    assign w_is_mt      = (op == 4'd7) || (op == 4'd8);
    assign w_mul_signed = (op == 4'd1) || (op == 4'd9) || (op == 4'd11);
    assign w_div_signed = (op == 4'd3);

    assign w_opa  = {{WIDTH{w_mul_signed & src_a[WIDTH-1]}}, src_a};
    assign w_opb  = {{WIDTH{w_mul_signed & src_b[WIDTH-1]}}, src_b};
    assign w_prod = w_opa * w_opb;

    assign w_a_abs = (w_div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_b_abs = (w_div_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Remainder is always below the divisor, so WIDTH+1 bits hold the trial subtraction.
    assign w_rem   = acc_q[2*WIDTH-1:WIDTH];
    assign w_quo   = acc_q[WIDTH-1:0];
    assign w_diff  = {w_rem, w_quo[WIDTH-1]} - {1'b0, dvs_q};
    assign w_q_fix = negq_q ? -w_quo : w_quo;
    assign w_r_fix = negr_q ? -w_rem : w_rem;

    assign w_hilo = {hi_q, lo_q};
`ifdef MDU_MADD_EN
    always_comb begin
        w_mul_wr = acc_q;
        if (mode_q == C_MODE_ADD) begin
            w_mul_wr = w_hilo + acc_q;
        end else if (mode_q == C_MODE_SUB) begin
            w_mul_wr = w_hilo - acc_q;
        end
    end
`else
    assign w_mul_wr = acc_q;
`endif

    assign busy     = (state_q != ST_IDLE);
    assign done     = ~flush & (((state_q == ST_MUL) && (cnt_q == C_CNT_ONE)) || (state_q == ST_FIX));
    assign div_zero = divz_q;
    assign result   = (op == 4'd5) ? hi_q : ((op == 4'd6) ? lo_q : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        divz_d  = divz_q;
`ifdef MDU_MADD_EN
        mode_d  = mode_q;
`endif
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept && (w_is_mt || w_is_mul || w_is_div || w_is_acc)) begin
                        divz_d = 1'b0;
                        if (op == 4'd7) begin
                            hi_d = src_a;
                        end
                        if (op == 4'd8) begin
                            lo_d = src_a;
                        end
                        if (w_is_mul || w_is_acc) begin
                            acc_d   = w_prod;
                            state_d = ST_MUL;
                            cnt_d   = C_MUL_LOAD;
`ifdef MDU_MADD_EN
                            mode_d  = w_is_mul ? C_MODE_SET :
                                      ((op <= 4'd10) ? C_MODE_ADD : C_MODE_SUB);
`endif
                        end
                        if (w_is_div) begin
                            if (src_b == '0) begin
                                divz_d = 1'b1;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, w_a_abs};
                                dvs_d   = w_b_abs;
                                negq_d  = w_div_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                negr_d  = w_div_signed & src_a[WIDTH-1];
                                state_d = ST_DIV;
                                cnt_d   = C_DIV_LOAD;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_q == C_CNT_ONE) begin
                        {hi_d, lo_d} = w_mul_wr;
                        state_d      = ST_IDLE;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q - C_CNT_ONE;
                    end
                end
                ST_DIV: begin
                    if (!w_diff[WIDTH]) begin
                        acc_d = {w_diff[WIDTH-1:0], w_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {w_rem[WIDTH-2:0], w_quo, 1'b0};
                    end
                    cnt_d = cnt_q - C_CNT_ONE;
                    if (cnt_q == C_CNT_ONE) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_d    = w_r_fix;
                    lo_d    = w_q_fix;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
`ifdef MDU_MADD_EN
            mode_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            divz_q  <= divz_d;
`ifdef MDU_MADD_EN
            mode_q  <= mode_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter_hilo.sv
// ============================================================================
// Module   : tb_mdu_iter_hilo
// Brief    : Directed self-checking bench for mdu_iter_hilo (WIDTH=32, MULT_CYCLES=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter_hilo;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_assert;
    int n_fail;

    mdu_iter_hilo #(.WIDTH(32), .MULT_CYCLES(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(output logic [63:0] v);
        op = 4'd5;
        #1 v[63:32] = result;
        op = 4'd6;
        #1 v[31:0] = result;
        op = 4'd0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
    endtask

    // Counts busy cycles after acceptance and records the busy cycle in which done showed.
    task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cycles, output int done_at);
        cycles  = 0;
        done_at = 0;
        issue(o, a, b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                if (done) done_at = -1;
                break;
            end
            cycles++;
            if (done) done_at = cycles;
        end
    endtask

    initial begin
        logic [63:0] hl;
        int          cyc;
        int          dat;
        int          dseen;

        n_assert = 0;
        n_fail   = 0;
        reset = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        src_a = '0;
        src_b = '0;
        flush = 1'b0;

        #2;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_divz", {63'd0, div_zero}, 64'd0);
        read_hilo(hl);
        chk("reset_hilo", hl, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // mult -3 * 5
        run(4'd1, 32'hFFFF_FFFD, 32'd5, cyc, dat);
        chk("mult_busy_cycles", 64'(cyc), 64'd5);
        chk("mult_done_cycle", 64'(dat), 64'd5);
        read_hilo(hl);
        chk("mult_hilo", hl, 64'hFFFF_FFFF_FFFF_FFF1);

        // divu 100 / 7
        run(4'd4, 32'd100, 32'd7, cyc, dat);
        chk("divu_busy_cycles", 64'(cyc), 64'd33);
        chk("divu_done_cycle", 64'(dat), 64'd33);
        read_hilo(hl);
        chk("divu_hilo", hl, {32'd2, 32'd14});

        // div -7 / 2
        run(4'd3, 32'hFFFF_FFF9, 32'd2, cyc, dat);
        read_hilo(hl);
        chk("div_neg_hilo", hl, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // div 7 / -2 : quotient -3, remainder keeps dividend sign (+1)
        run(4'd3, 32'd7, 32'hFFFF_FFFE, cyc, dat);
        read_hilo(hl);
        chk("div_negb_hilo", hl, {32'd1, 32'hFFFF_FFFD});

        // most-negative / -1
        run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dat);
        read_hilo(hl);
        chk("div_ovf_hilo", hl, {32'd0, 32'h8000_0000});
        chk("div_ovf_divz", {63'd0, div_zero}, 64'd0);

        // div by zero
        run(4'd3, 32'd5, 32'd0, cyc, dat);
        chk("divz_busy_cycles", 64'(cyc), 64'd0);
        chk("divz_no_done", 64'(dat), 64'd0);
        chk("divz_flag", {63'd0, div_zero}, 64'd1);
        read_hilo(hl);
        chk("divz_hilo_kept", hl, {32'd0, 32'h8000_0000});

        // mthi clears div_zero, no busy
        run(4'd7, 32'h1234, 32'd0, cyc, dat);
        chk("mthi_busy_cycles", 64'(cyc), 64'd0);
        chk("mthi_divz_clear", {63'd0, div_zero}, 64'd0);
        read_hilo(hl);
        chk("mthi_hilo", hl, {32'h1234, 32'h8000_0000});

        // divu 9/2 flushed in busy cycle 10
        issue(4'd4, 32'd9, 32'd2);
        dseen = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) dseen = 1;
        end
        chk("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        #1 if (done) dseen = 1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy_after", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dseen = 1;
        end
        chk("flush_no_done", 64'(dseen), 64'd0);
        read_hilo(hl);
        chk("flush_hilo_kept", hl, {32'h1234, 32'h8000_0000});

        // start together with flush: mtlo must not take effect
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 4'd8;
        src_a = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        op    = 4'd0;
        read_hilo(hl);
        chk("start_flush_ignored", hl, {32'h1234, 32'h8000_0000});

        // accumulate ops
        run(4'd8, 32'd10, 32'd0, cyc, dat);
        run(4'd7, 32'd0, 32'd0, cyc, dat);
        read_hilo(hl);
        chk("mt_setup_hilo", hl, 64'd10);
        run(4'd9, 32'd3, 32'd4, cyc, dat);
`ifdef MDU_MADD_EN
        chk("madd_busy_cycles", 64'(cyc), 64'd5);
        read_hilo(hl);
        chk("madd_hilo", hl, 64'd22);
`else
        chk("madd_off_busy", 64'(cyc), 64'd0);
        chk("madd_off_done", 64'(dat), 64'd0);
        read_hilo(hl);
        chk("madd_off_hilo", hl, 64'd10);
`endif
        run(4'd12, 32'hFFFF_FFFF, 32'd2, cyc, dat);
        read_hilo(hl);
`ifdef MDU_MADD_EN
        chk("msubu_hilo", hl, 64'hFFFF_FFFE_0000_0018);
`else
        chk("msubu_off_hilo", hl, 64'd10);
`endif

        // mult while busy is ignored
        issue(4'd1, 32'd7, 32'd9);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 4'd1;
        src_a = 32'd2;
        src_b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
        dseen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy) dseen = 1;
        end
        chk("busy_start_not_queued", 64'(dseen), 64'd0);
        read_hilo(hl);
        chk("busy_start_hilo", hl, 64'd63);

        // asynchronous reset mid-multiply
        issue(4'd1, 32'd3, 32'd3);
        @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_busy", {63'd0, busy}, 64'd0);
        read_hilo(hl);
        chk("async_reset_hilo", hl, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
